// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: the CDB result record and per-instance defaults.
package expipe_pkg;

  localparam int XLEN             = 32;
  localparam int ROB_IDX_W        = 5;
  localparam int EU_CDB_BUF_DEPTH = 4;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      value;
    logic                 except_raised;
  } cdb_data_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/eu_cdb_buffer_modn_counter.sv
// Wrapping W-bit pointer with increment enable and synchronous clear.
module modn_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment so a flush discards a concurrent advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eu_cdb_buffer.sv
// Circular result FIFO between one execution unit and its low-priority CDB port.
module eu_cdb_buffer
  import expipe_pkg::*;
#(
  parameter int DEPTH = EU_CDB_BUF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     eu_valid_i,
  output logic                     eu_ready_o,
  input  cdb_data_t                eu_data_i,
  output logic                     cdb_valid_o,
  input  logic                     cdb_ready_i,
  output cdb_data_t                cdb_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  cdb_data_t         mem [DEPTH];
  logic [AW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; ready/valid here depend only on occupancy, and flush voids either transfer.
  assign eu_ready_o  = (count_q != FULL);
  assign cdb_valid_o = (count_q != '0);
  assign push        = eu_valid_i & eu_ready_o & ~flush_i;
  assign pop         = cdb_valid_o & cdb_ready_i & ~flush_i;

  modn_counter #(.W(AW)) u_head (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .en_i    (pop),
    .cnt_o   (head_q)
  );

  modn_counter #(.W(AW)) u_tail (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .en_i    (push),
    .cnt_o   (tail_q)
  );

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  // Storage is deliberately unreset; empty-state output is masked instead.
  always_ff @(posedge clk_i) begin
    if (push) mem[tail_q] <= eu_data_i;
  end

  assign cdb_data_o = cdb_valid_o ? mem[head_q] : '0;
  assign count_o    = count_q;

`ifndef SYNTHESIS
  a_depth_legal: assert property (@(posedge clk_i) (DEPTH >= 2) && is_pow2(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (count_q == FULL) |-> !push);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (count_q == '0) |-> !pop);
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    count_q <= FULL);
  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (cdb_valid_o && !cdb_ready_i && !flush_i) |=> $stable(cdb_data_o));
`endif

endmodule

// File: tb/tb_eu_cdb_buffer.sv
// Bench for eu_cdb_buffer: directed scenarios plus random traffic against a queue model.
module tb_eu_cdb_buffer;
  import expipe_pkg::*;

  localparam int DEPTH = EU_CDB_BUF_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            eu_valid = 1'b0;
  logic            eu_ready;
  cdb_data_t       eu_data = '0;
  logic            cdb_valid;
  logic            cdb_ready = 1'b0;
  cdb_data_t       cdb_data;
  logic [CW-1:0]   count;

  int n_tests = 0;
  int n_fail  = 0;
  cdb_data_t exp_q[$];

  always #5 clk = ~clk;

  eu_cdb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .eu_valid_i  (eu_valid),
    .eu_ready_o  (eu_ready),
    .eu_data_i   (eu_data),
    .cdb_valid_o (cdb_valid),
    .cdb_ready_i (cdb_ready),
    .cdb_data_o  (cdb_data),
    .count_o     (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the queue model's view of the buffer.
  task automatic chk_outputs(input string tag);
    cdb_data_t head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk({tag, ".count"},     64'(count),     64'(exp_q.size()));
    chk({tag, ".cdb_valid"}, 64'(cdb_valid), 64'(exp_q.size() != 0));
    chk({tag, ".eu_ready"},  64'(eu_ready),  64'(exp_q.size() < DEPTH));
    chk({tag, ".cdb_data"},  64'(cdb_data),  64'(head));
  endtask

  // One clock: drive inputs, check outputs, advance model on the edge.
  task automatic cycle(input string tag, input logic v, input logic r,
                       input logic fl, input cdb_data_t d);
    bit do_push, do_pop;
    eu_valid  = v;
    cdb_ready = r;
    flush     = fl;
    eu_data   = d;
    #1;
    chk_outputs(tag);
    do_push = v && (exp_q.size() < DEPTH) && !fl;
    do_pop  = r && (exp_q.size() != 0) && !fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    #1;
  endtask

  function automatic cdb_data_t mk(input int idx, input logic [31:0] val, input logic ex);
    cdb_data_t d;
    d.rob_idx       = ROB_IDX_W'(idx);
    d.value         = val;
    d.except_raised = ex;
    return d;
  endfunction

  function automatic cdb_data_t rand_data();
    return mk(int'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
  endfunction

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * DEPTH && exp_q.size() != 0; i++) cycle(tag, 1'b0, 1'b1, 1'b0, '0);
    #1;
    chk({tag, ".empty"}, 64'(count), 64'(0));
  endtask

  initial begin
    int acc;

    // Reset held with the EU trying to push.
    eu_valid = 1'b1;
    eu_data  = mk(7, 32'hdead, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset.cdb_valid", 64'(cdb_valid), 64'(0));
    chk("reset.eu_ready",  64'(eu_ready),  64'(1));
    chk("reset.count",     64'(count),     64'(0));
    chk("reset.cdb_data",  64'(cdb_data),  64'(0));
    eu_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_reset", 1'b0, 1'b0, 1'b0, '0);

    // Fill to full with the CDB stalled, then try one more push.
    for (int i = 1; i <= 4; i++)
      cycle("fill", 1'b1, 1'b0, 1'b0, mk(i, 32'(i * 'h11), 1'b0));
    chk("full.count",    64'(count),    64'(DEPTH));
    chk("full.eu_ready", 64'(eu_ready), 64'(0));
    cycle("push_when_full", 1'b1, 1'b0, 1'b0, mk(9, 32'h99, 1'b1));
    drain("drain_fill");

    // Simultaneous push and pop at count 2.
    cycle("sim_pre", 1'b1, 1'b0, 1'b0, mk(1, 32'h101, 1'b0));
    cycle("sim_pre", 1'b1, 1'b0, 1'b0, mk(2, 32'h202, 1'b1));
    cycle("sim_both", 1'b1, 1'b1, 1'b0, mk(5, 32'h505, 1'b0));
    chk("sim.count", 64'(count), 64'(2));
    drain("drain_sim");

    // Wrap-around stream with toggling ready.
    acc = 0;
    for (int c = 0; c < 100 && acc < 10; c++) begin
      cdb_data_t d;
      d = mk(10 + acc, $urandom, 1'($urandom_range(0, 1)));
      if (exp_q.size() < DEPTH) acc++;
      cycle("wrap", 1'b1, 1'(c % 2), 1'b0, d);
    end
    chk("wrap.accepted", 64'(acc), 64'(10));
    drain("drain_wrap");

    // Flush with three entries while both sides try to transfer.
    for (int i = 0; i < 3; i++) cycle("flush_pre", 1'b1, 1'b0, 1'b0, rand_data());
    cycle("flush", 1'b1, 1'b1, 1'b1, mk(3, 32'h333, 1'b1));
    chk("flush.count",     64'(count),     64'(0));
    chk("flush.cdb_valid", 64'(cdb_valid), 64'(0));
    cycle("post_flush", 1'b0, 1'b0, 1'b0, '0);

    // Long backpressure on a single entry carrying an exception.
    cycle("bp_push", 1'b1, 1'b0, 1'b0, mk(17, 32'hcafe_f00d, 1'b1));
    for (int i = 0; i < 20; i++) cycle("bp_hold", 1'b0, 1'b0, 1'b0, '0);
    chk("bp.except", 64'(cdb_data.except_raised), 64'(1));
    drain("drain_bp");

    // Random traffic including occasional flushes.
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0), rand_data());
    drain("drain_rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
